axis_payload_length_buffer: RTL and testbench

- Store-and-forward stage directly upstream of the IPv4 header generator.
- Accepts a byte-wide payload AXI stream and buffers each whole packet.
- Once tlast is seen, emits the packet's byte count on a 16-bit length stream, which feeds the header generator's payload_length input.
- Replays the buffered payload bytes so they can follow the generated header.

---
 rtl/axis_payload_length_buffer.sv | 237 +++++++++++++++++++++++
 tb/tb_axis_payload_length_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_payload_length_buffer.sv
// axis_payload_length_buffer: store-and-forward stage ahead of the IPv4 header generator.
// Buffers each whole byte-wide payload packet, then emits its byte count on a 16-bit length
// stream and replays the bytes on the payload output stream.
// Optional: define PAYLOAD_LEN_BUF_DROP_CNT_EN to add the saturating drop_count output.
module axis_payload_length_buffer #(
   parameter int unsigned DEPTH    = 2048,
   parameter int unsigned MAX_PKTS = 16
) (
   input  logic        clk,
   input  logic        sreset,
   output logic        axis_i_tready,
   input  logic        axis_i_tvalid,
   input  logic        axis_i_tlast,
   input  logic [7:0]  axis_i_tdata,
   input  logic        axis_o_tready,
   output logic        axis_o_tvalid,
   output logic        axis_o_tlast,
   output logic [7:0]  axis_o_tdata,
   input  logic        length_axis_tready,
   output logic        length_axis_tvalid,
   output logic        length_axis_tlast,
   output logic [15:0] length_axis_tdata
`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
   ,
   output logic [15:0] drop_count
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(MAX_PKTS);
   localparam logic [AW:0] PtrOne = (AW + 1)'(1);
   localparam logic [LW:0] LenOne = (LW + 1)'(1);
   localparam logic [LW:0] LenMax = (LW + 1)'(MAX_PKTS);
   localparam logic [15:0] DepthCnt = 16'(DEPTH);

   typedef enum logic [1:0] {StIdle, StFill, StDrop} state_e;

   state_e      state_q;
   logic        init_q;
   logic [15:0] byte_cnt_q;
   logic [AW:0] wr_ptr_q, cmt_ptr_q, rd_ptr_q;

   logic [8:0]  ram [DEPTH];
   logic [8:0]  ram_rdata_q;
   logic        rd_vld_q;
   logic [8:0]  sk0_q, sk1_q;
   logic [1:0]  sk_cnt_q;

   logic [15:0] len_mem [MAX_PKTS];
   logic [LW:0] len_wr_q, len_rd_q, len_cnt_q;
   logic        len_vld_q;
   logic [15:0] len_data_q;

   logic        ram_full, len_full, at_max, rdy, in_fire, wr_en, commit;
   logic [15:0] len_push_data;
   logic        len_pop, len_load, len_mem_empty, len_bypass, len_mem_we;
   logic        avail, o_pop, rd_en;
   logic [1:0]  occ_next;

   // Input-side flow control and write/commit decode.
   always_comb begin
      ram_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      len_full = (len_cnt_q == LenMax);
      at_max   = (byte_cnt_q == DepthCnt);
      rdy      = 1'b0;
      unique case (state_q)
         StIdle:  rdy = !len_full && !ram_full;
         // A packet that already fills the buffer must keep flowing so it can be dropped.
         StFill:  rdy = !ram_full || at_max;
         StDrop:  rdy = 1'b1;
         default: rdy = 1'b0;
      endcase
      axis_i_tready = rdy && init_q && !sreset;
      in_fire       = axis_i_tvalid && axis_i_tready;
      wr_en         = in_fire && ((state_q == StIdle) || ((state_q == StFill) && !at_max));
      commit        = wr_en && axis_i_tlast;
      len_push_data = (state_q == StIdle) ? 16'd1 : byte_cnt_q + 16'd1;
   end

   // Input FSM: fill, commit on tlast, or rewind and discard an oversize packet.
   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q    <= StIdle;
         init_q     <= 1'b0;
         byte_cnt_q <= '0;
         wr_ptr_q   <= '0;
         cmt_ptr_q  <= '0;
      end else begin
         init_q <= 1'b1;
         if (in_fire) begin
            unique case (state_q)
               StIdle: begin
                  wr_ptr_q   <= wr_ptr_q + PtrOne;
                  byte_cnt_q <= 16'd1;
                  if (axis_i_tlast) cmt_ptr_q <= wr_ptr_q + PtrOne;
                  else              state_q   <= StFill;
               end
               StFill: begin
                  if (at_max) begin
                     wr_ptr_q <= cmt_ptr_q;
                     state_q  <= axis_i_tlast ? StIdle : StDrop;
                  end else begin
                     wr_ptr_q   <= wr_ptr_q + PtrOne;
                     byte_cnt_q <= byte_cnt_q + 16'd1;
                     if (axis_i_tlast) begin
                        cmt_ptr_q <= wr_ptr_q + PtrOne;
                        state_q   <= StIdle;
                     end
                  end
               end
               StDrop: begin
                  if (axis_i_tlast) state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   logic        drop;

   assign drop       = in_fire && (state_q == StFill) && at_max;
   assign drop_count = drop_cnt_q;

   // Saturating count of oversize packets discarded.
   always_ff @(posedge clk) begin
      if (sreset) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end
`endif

   // Read-side issue: only committed bytes, and only when the skid can absorb the result.
   always_comb begin
      avail    = (cmt_ptr_q != rd_ptr_q);
      o_pop    = axis_o_tvalid && axis_o_tready;
      occ_next = sk_cnt_q + {1'b0, rd_vld_q} - {1'b0, o_pop};
      rd_en    = avail && (occ_next < 2'd2);
   end

   // Payload RAM, {tlast, data} per entry, with a registered read port.
   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_ptr_q[AW-1:0]] <= {axis_i_tlast, axis_i_tdata};
      if (rd_en) ram_rdata_q <= ram[rd_ptr_q[AW-1:0]];
   end

   // Read pointer and 2-entry output skid; sk0_q is the presented beat.
   always_ff @(posedge clk) begin
      if (sreset) begin
         rd_ptr_q <= '0;
         rd_vld_q <= 1'b0;
         sk0_q    <= '0;
         sk1_q    <= '0;
         sk_cnt_q <= '0;
      end else begin
         rd_vld_q <= rd_en;
         if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
         case ({rd_vld_q, o_pop})
            2'b11: begin
               if (sk_cnt_q == 2'd2) begin
                  sk0_q <= sk1_q;
                  sk1_q <= ram_rdata_q;
               end else begin
                  sk0_q <= ram_rdata_q;
               end
            end
            2'b01: begin
               sk0_q    <= sk1_q;
               sk_cnt_q <= sk_cnt_q - 2'd1;
            end
            2'b10: begin
               if (sk_cnt_q == 2'd0) sk0_q <= ram_rdata_q;
               else                  sk1_q <= ram_rdata_q;
               sk_cnt_q <= sk_cnt_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign axis_o_tvalid = (sk_cnt_q != 2'd0);
   assign axis_o_tdata  = sk0_q[7:0];
   assign axis_o_tlast  = axis_o_tvalid && sk0_q[8];

   // Length FIFO control; the output register counts toward MAX_PKTS occupancy.
   always_comb begin
      len_pop       = len_vld_q && length_axis_tready;
      len_load      = !len_vld_q || length_axis_tready;
      len_mem_empty = (len_wr_q == len_rd_q);
      len_bypass    = commit && len_load && len_mem_empty;
      len_mem_we    = commit && !len_bypass;
   end

   // Length FIFO storage.
   always_ff @(posedge clk) begin
      if (len_mem_we) len_mem[len_wr_q[LW-1:0]] <= len_push_data;
   end

   // Length FIFO pointers, occupancy and registered output word.
   always_ff @(posedge clk) begin
      if (sreset) begin
         len_wr_q   <= '0;
         len_rd_q   <= '0;
         len_cnt_q  <= '0;
         len_vld_q  <= 1'b0;
         len_data_q <= '0;
      end else begin
         if (len_mem_we) len_wr_q <= len_wr_q + LenOne;
         if (len_load) begin
            if (!len_mem_empty) begin
               len_data_q <= len_mem[len_rd_q[LW-1:0]];
               len_rd_q   <= len_rd_q + LenOne;
               len_vld_q  <= 1'b1;
            end else if (commit) begin
               len_data_q <= len_push_data;
               len_vld_q  <= 1'b1;
            end else begin
               len_vld_q <= 1'b0;
            end
         end
         case ({commit, len_pop})
            2'b10:   len_cnt_q <= len_cnt_q + LenOne;
            2'b01:   len_cnt_q <= len_cnt_q - LenOne;
            default: ;
         endcase
      end
   end

   assign length_axis_tvalid = len_vld_q;
   assign length_axis_tlast  = len_vld_q;
   assign length_axis_tdata  = len_data_q;

endmodule

// File: tb/tb_axis_payload_length_buffer.sv
// Self-checking bench for axis_payload_length_buffer with DEPTH = 16, MAX_PKTS = 4.
module tb_axis_payload_length_buffer;

   localparam int unsigned Depth   = 16;
   localparam int unsigned MaxPkts = 4;

   logic        clk = 1'b0;
   logic        sreset = 1'b1;
   logic        in_rdy;
   logic        in_vld = 1'b0;
   logic        in_last = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        o_rdy = 1'b0;
   logic        o_vld, o_last;
   logic [7:0]  o_data;
   logic        l_rdy = 1'b0;
   logic        l_vld, l_last;
   logic [15:0] l_data;
`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
   logic [15:0] drop_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   int o_mode = 0;  // 0: ready low, 1: ready high, 2: random
   int l_mode = 0;
   bit gap_en = 1'b0;
   int exp_drops = 0;
   logic [8:0]  exp_byte[$];
   logic [15:0] exp_len[$];

   typedef struct {
      int          len;
      logic [7:0]  base;
      logic [15:0] exp_len;   // 0 marks a packet that must be dropped
      int          exp_drops; // cumulative drops after this packet
   } vec_t;
   vec_t vecs[9];

   axis_payload_length_buffer #(
      .DEPTH    (Depth),
      .MAX_PKTS (MaxPkts)
   ) dut (
      .clk                (clk),
      .sreset             (sreset),
      .axis_i_tready      (in_rdy),
      .axis_i_tvalid      (in_vld),
      .axis_i_tlast       (in_last),
      .axis_i_tdata       (in_data),
      .axis_o_tready      (o_rdy),
      .axis_o_tvalid      (o_vld),
      .axis_o_tlast       (o_last),
      .axis_o_tdata       (o_data),
      .length_axis_tready (l_rdy),
      .length_axis_tvalid (l_vld),
      .length_axis_tlast  (l_last),
      .length_axis_tdata  (l_data)
`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
      ,
      .drop_count         (drop_count)
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Output-ready drivers.
   initial forever begin
      @(negedge clk);
      o_rdy = (o_mode == 1) ? 1'b1 : (o_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      l_rdy = (l_mode == 1) ? 1'b1 : (l_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
   end

   // Payload scoreboard.
   initial begin : mon_payload
      logic [8:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (!sreset && o_vld && o_rdy) begin
            if (exp_byte.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL payload_unexpected got=%h want=none", {o_last, o_data});
            end else begin
               e = exp_byte.pop_front();
               check("payload_byte", {23'd0, o_last, o_data}, {23'd0, e});
            end
         end
      end
   end

   // Length scoreboard.
   initial begin : mon_length
      logic [15:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (!sreset && l_vld && l_rdy) begin
            if (exp_len.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL length_unexpected got=%0d want=none", l_data);
            end else begin
               e = exp_len.pop_front();
               check("length_value", {16'd0, l_data}, {16'd0, e});
               check("length_tlast", {31'd0, l_last}, 32'd1);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic expect_pkt(input int len, input logic [7:0] base);
      exp_len.push_back(16'(len));
      for (int i = 0; i < len; i++) exp_byte.push_back({(i == len - 1), 8'(base + 8'(i))});
   endtask

   task automatic send_pkt(input int len, input logic [7:0] base, input bit with_last);
      int i = 0;
      int wait_c = 0;
      bit holding = 1'b0;
      while (i < len) begin
         @(negedge clk);
         if (gap_en && !holding && ($urandom_range(0, 3) == 0)) begin
            in_vld = 1'b0;
         end else begin
            holding = 1'b1;
            in_vld  = 1'b1;
            in_data = base + 8'(i);
            in_last = with_last && (i == len - 1);
            #1;
            if (in_rdy) begin
               i++;
               holding = 1'b0;
               wait_c  = 0;
            end else begin
               wait_c++;
               if (wait_c > 2000) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL in_accept_timeout beat=%0d got ready=0 want 1", i);
                  break;
               end
            end
         end
      end
      @(negedge clk);
      in_vld  = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while ((exp_byte.size() != 0 || exp_len.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("drain_left", exp_byte.size() + exp_len.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int bubbles;
      int stalled;
      int rl;

      vecs[0] = '{4,  8'h01, 16'd4,  0};
      vecs[1] = '{1,  8'hAA, 16'd1,  0};
      vecs[2] = '{16, 8'h10, 16'd16, 0};
      vecs[3] = '{20, 8'h30, 16'd0,  1};
      vecs[4] = '{3,  8'h50, 16'd3,  1};
      vecs[5] = '{2,  8'hFE, 16'd2,  1};
      vecs[6] = '{17, 8'h60, 16'd0,  2};
      vecs[7] = '{15, 8'h80, 16'd15, 2};
      vecs[8] = '{5,  8'hC0, 16'd5,  2};

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_rdy}, 32'd0);
      check("rst_o_valid", {31'd0, o_vld}, 32'd0);
      check("rst_o_last", {31'd0, o_last}, 32'd0);
      check("rst_o_data", {24'd0, o_data}, 32'd0);
      check("rst_l_valid", {31'd0, l_vld}, 32'd0);
      check("rst_l_last", {31'd0, l_last}, 32'd0);
      check("rst_l_data", {16'd0, l_data}, 32'd0);
      @(negedge clk);
      sreset = 1'b0;
      #1;
      check("ready_first_cycle", {31'd0, in_rdy}, 32'd0);
      @(negedge clk);
      #1;
      check("ready_after_init", {31'd0, in_rdy}, 32'd1);
`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
      check("drop_count_reset", {16'd0, drop_count}, 32'd0);
`endif

      // Directed vector table.
      l_mode = 1;
      for (int k = 0; k < 9; k++) begin
         o_mode = (k % 2 == 0) ? 1 : 2;
         if (vecs[k].exp_len != 16'd0) begin
            exp_len.push_back(vecs[k].exp_len);
            for (int i = 0; i < vecs[k].len; i++)
               exp_byte.push_back({(i == vecs[k].len - 1), 8'(vecs[k].base + 8'(i))});
         end
         send_pkt(vecs[k].len, vecs[k].base, 1'b1);
         drain(2000);
`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
         check("drop_count", {16'd0, drop_count}, vecs[k].exp_drops);
`endif
      end
      exp_drops = vecs[8].exp_drops;

      // Length FIFO full blocks a fifth packet until lengths are taken.
      o_mode = 1;
      l_mode = 0;
      for (int k = 0; k < 5; k++) expect_pkt(2, 8'h70 + 8'(2 * k));
      for (int k = 0; k < 4; k++) send_pkt(2, 8'h70 + 8'(2 * k), 1'b1);
      stalled = 0;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (!in_rdy) stalled++;
      end
      check("len_full_blocks_start", stalled, 5);
      l_mode = 1;
      send_pkt(2, 8'h78, 1'b1);
      drain(2000);

      // Buffered bytes replay without bubbles once ready is held high.
      o_mode = 0;
      for (int k = 0; k < 4; k++) begin
         expect_pkt(4, 8'hA0 + 8'(16 * k));
         send_pkt(4, 8'hA0 + 8'(16 * k), 1'b1);
      end
      repeat (4) @(negedge clk);
      #1;
      o_mode = 1;
      bubbles = 0;
      repeat (16) begin
         @(negedge clk);
         #1;
         if (!o_vld) bubbles++;
      end
      check("zero_bubbles", bubbles, 0);
      drain(2000);

      // Random backpressure on all ports.
      o_mode = 2;
      l_mode = 2;
      gap_en = 1'b1;
      for (int k = 0; k < 200; k++) begin
         rl = $urandom_range(1, Depth);
         expect_pkt(rl, 8'($urandom));
         send_pkt(rl, exp_byte[exp_byte.size() - rl][7:0], 1'b1);
      end
      drain(30000);
      gap_en = 1'b0;

      // Reset mid-readout and mid-fill.
      o_mode = 0;
      l_mode = 1;
      expect_pkt(10, 8'h20);
      send_pkt(10, 8'h20, 1'b1);
      o_mode = 2;
      send_pkt(5, 8'h40, 1'b0);
      sreset = 1'b1;
      exp_byte.delete();
      exp_len.delete();
      exp_drops = 0;
      @(negedge clk);
      sreset = 1'b0;
      #1;
      check("mid_rst_in_ready", {31'd0, in_rdy}, 32'd0);
      check("mid_rst_o_valid", {31'd0, o_vld}, 32'd0);
      check("mid_rst_o_last", {31'd0, o_last}, 32'd0);
      check("mid_rst_o_data", {24'd0, o_data}, 32'd0);
      check("mid_rst_l_valid", {31'd0, l_vld}, 32'd0);
      check("mid_rst_l_data", {16'd0, l_data}, 32'd0);
`ifdef PAYLOAD_LEN_BUF_DROP_CNT_EN
      check("mid_rst_drop_count", {16'd0, drop_count}, exp_drops);
`endif
      @(negedge clk);
      #1;
      check("mid_rst_ready_back", {31'd0, in_rdy}, 32'd1);
      o_mode = 1;
      expect_pkt(3, 8'hD0);
      send_pkt(3, 8'hD0, 1'b1);
      drain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
